// File: rtl/uart_pkg.sv
// Shared UART types and defaults for the receiver and the baud tick generator.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;

  localparam int unsigned UART_RATIO = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs; flops reset to all ones (idle line level).
module uart_rx_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, 3-sample majority vote, LSB-first shift, stop check.
// Optional parity stage and parity_err_o port are enabled with `define UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned RATIO      = UART_RATIO,
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 uart_ce_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 frame_err_o,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err_o,
`endif
  output logic                 busy_o
);

  localparam int unsigned TW = $clog2(RATIO);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_S0   = TW'(RATIO / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(RATIO / 2);
  localparam logic [TW-1:0] T_DEC  = TW'(RATIO / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(RATIO - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  if (RATIO < 4 || (RATIO % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (PARITY_ODD !== 1'b0 && PARITY_ODD !== 1'b1)) begin : g_param_check
    $error("uart_rx: illegal parameter combination");
  end

  uart_rx_state_t       r_state, w_state_nxt;
  logic [TW-1:0]        r_tick, w_tick_nxt;
  logic [BW-1:0]        r_bit, w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic                 r_armed, w_armed_nxt;
  logic                 r_s0, w_s0_nxt;
  logic                 r_s1, w_s1_nxt;
  logic                 w_valid_nxt, w_ferr_nxt;
  logic                 w_rx_s, w_vote, w_dec, w_last;
`ifdef UART_RX_PARITY_EN
  logic                 r_par, w_par_nxt;
  logic                 w_perr_nxt, w_par_bad;
`endif

  uart_rx_sync #(.WIDTH(1)) u_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (rx_i),
    .q_o    (w_rx_s)
  );

  // Third vote sample is the live synchronised line at the decision tick.
  assign w_vote = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
  assign w_dec  = (r_tick == T_DEC);
  assign w_last = (r_tick == T_LAST);
  assign busy_o = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign w_par_bad = ((^{r_shift, r_par}) != PARITY_ODD);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_armed_nxt = r_armed;
    w_s0_nxt    = r_s0;
    w_s1_nxt    = r_s1;
    w_data_nxt  = data_o;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
    w_perr_nxt  = 1'b0;
`endif
    if (uart_ce_i) begin
      if (r_state != IDLE) begin
        w_tick_nxt = w_last ? '0 : r_tick + 1'b1;
        if (r_tick == T_S0) w_s0_nxt = w_rx_s;
        if (r_tick == T_S1) w_s1_nxt = w_rx_s;
      end
      case (r_state)
        IDLE: begin
          if (w_rx_s) begin
            w_armed_nxt = 1'b1;
          end else if (r_armed) begin
            w_state_nxt = START;
            w_tick_nxt  = TW'(1);
          end
        end
        START: begin
          if (w_dec && w_vote) begin
            w_state_nxt = IDLE;
            w_tick_nxt  = '0;
          end else if (w_last) begin
            w_state_nxt = DATA;
            w_bit_nxt   = '0;
          end
        end
        DATA: begin
          if (w_dec) w_shift_nxt = {w_vote, r_shift[DATA_BITS-1:1]};
          if (w_last) begin
            if (r_bit == B_LAST) begin
              w_bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
              w_state_nxt = PARITY;
`else
              w_state_nxt = STOP;
`endif
            end else begin
              w_bit_nxt = r_bit + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_dec)  w_par_nxt   = w_vote;
          if (w_last) w_state_nxt = STOP;
        end
`endif
        STOP: begin
          // Leave at the decision tick so a back-to-back start bit is not missed.
          if (w_dec) begin
            w_data_nxt  = r_shift;
            w_ferr_nxt  = ~w_vote;
            w_armed_nxt = w_vote;
            w_state_nxt = IDLE;
            w_tick_nxt  = '0;
`ifdef UART_RX_PARITY_EN
            w_perr_nxt  = w_par_bad;
            w_valid_nxt = w_vote & ~w_par_bad;
`else
            w_valid_nxt = w_vote;
`endif
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_tick_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= IDLE;
      r_tick      <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_armed     <= 1'b0;
      r_s0        <= 1'b0;
      r_s1        <= 1'b0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par        <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_tick      <= w_tick_nxt;
      r_bit       <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_armed     <= w_armed_nxt;
      r_s0        <= w_s0_nxt;
      r_s1        <= w_s1_nxt;
      data_o      <= w_data_nxt;
      valid_o     <= w_valid_nxt;
      frame_err_o <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
      r_par        <= w_par_nxt;
      parity_err_o <= w_perr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scoreboard of expected frames popped on each output strobe.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned RATIO = UART_RATIO;
  localparam int unsigned DB    = 8;

  logic          clk = 1'b0;
  logic          rstn_i;
  logic          uart_ce_i;
  logic          rx_i;
  logic [DB-1:0] data_o;
  logic          valid_o;
  logic          frame_err_o;
  logic          parity_err_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  uart_rx #(.RATIO(RATIO), .DATA_BITS(DB), .PARITY_ODD(1'b0)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .uart_ce_i   (uart_ce_i),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
`ifdef UART_RX_PARITY_EN
    .parity_err_o(parity_err_o),
`endif
    .busy_o      (busy_o)
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err_o = 1'b0;
`endif

  always @(negedge clk) begin
    if (rstn_i && (valid_o || frame_err_o || parity_err_o)) begin
      checks++;
      if (valid_o && frame_err_o) begin
        errors++;
        $display("FAIL strobe_exclusive: valid_o=%b frame_err_o=%b, required not both high", valid_o, frame_err_o);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: valid=%b ferr=%b perr=%b data=%h, required no strobe",
                 valid_o, frame_err_o, parity_err_o, data_o);
      end else begin
        mon_e = sb.pop_front();
        if ({data_o, valid_o, frame_err_o, parity_err_o} !==
            {mon_e.data, ~(mon_e.ferr | mon_e.perr), mon_e.ferr, mon_e.perr}) begin
          errors++;
          $display("FAIL frame_result: data=%h valid=%b ferr=%b perr=%b, required data=%h valid=%b ferr=%b perr=%b",
                   data_o, valid_o, frame_err_o, parity_err_o, mon_e.data,
                   ~(mon_e.ferr | mon_e.perr), mon_e.ferr, mon_e.perr);
        end
      end
    end
  end

  // One ce period: rx set, three quiet clocks, then a one-clock ce pulse.
  task automatic step(input logic v);
    rx_i      = v;
    uart_ce_i = 1'b0;
    repeat (3) @(negedge clk);
    uart_ce_i = 1'b1;
    @(negedge clk);
    uart_ce_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic spike, input logic bad_par);
    logic p;
    repeat (RATIO) step(1'b0);
    for (int i = 0; i < int'(DB); i++)
      for (int t = 0; t < int'(RATIO); t++)
        step((spike && t == int'(RATIO / 2)) ? 1'b0 : d[i]);
    p = (^d) ^ bad_par;
`ifdef UART_RX_PARITY_EN
    repeat (RATIO) step(p);
`endif
    repeat (RATIO) step(stop);
  endtask

  task automatic test_reset;
    rstn_i    = 1'b0;
    rx_i      = 1'b1;
    uart_ce_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (data_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: data_o=%h, required 00", data_o);
    end
    checks++;
    if ({valid_o, frame_err_o, parity_err_o, busy_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: v/fe/pe/busy=%b, required 0000", {valid_o, frame_err_o, parity_err_o, busy_o});
    end
    rstn_i = 1'b1;
    idle(4);
  endtask

  task automatic test_valid_frame;
    sb.push_back('{8'h55, 1'b0, 1'b0});
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    idle(4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL valid_frame_drained: pending=%0d, required 0", sb.size());
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL valid_frame_busy: busy_o=%b, required 0", busy_o);
    end
  endtask

  task automatic test_frame_err;
    logic seen_busy;
    sb.push_back('{8'hA3, 1'b1, 1'b0});
    send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
    seen_busy = 1'b0;
    repeat (5 * RATIO) begin
      step(1'b0);
      if (busy_o) seen_busy = 1'b1;
    end
    checks++;
    if (seen_busy !== 1'b0) begin
      errors++;
      $display("FAIL break_no_restart: busy seen=%b, required 0", seen_busy);
    end
    idle(4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL frame_err_drained: pending=%0d, required 0", sb.size());
    end
    checks++;
    if (data_o !== 8'hA3) begin
      errors++;
      $display("FAIL frame_err_hold: data_o=%h, required a3", data_o);
    end
  endtask

  task automatic test_glitch;
    step(1'b0);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL glitch_start: busy_o=%b, required 1", busy_o);
    end
    step(1'b0);
    repeat (RATIO - 2) step(1'b1);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL glitch_abort: busy_o=%b, required 0", busy_o);
    end
    idle(4);
    checks++;
    if (data_o !== 8'hA3) begin
      errors++;
      $display("FAIL glitch_hold: data_o=%h, required a3", data_o);
    end
  endtask

  task automatic test_spike;
    sb.push_back('{8'hFF, 1'b0, 1'b0});
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
    idle(4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL spike_drained: pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_back_to_back;
    sb.push_back('{8'h00, 1'b0, 1'b0});
    sb.push_back('{8'hFF, 1'b0, 1'b0});
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    idle(4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_drained: pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    d = 8'h3C;
    repeat (RATIO) step(1'b0);
    for (int i = 0; i < 4; i++) repeat (RATIO) step(d[i]);
    repeat (3) step(d[4]);
    rstn_i = 1'b0;
    @(negedge clk);
    checks++;
    if (data_o !== 8'h00) begin
      errors++;
      $display("FAIL midframe_reset_data: data_o=%h, required 00", data_o);
    end
    checks++;
    if ({valid_o, frame_err_o, busy_o} !== 3'b000) begin
      errors++;
      $display("FAIL midframe_reset_flags: v/fe/busy=%b, required 000", {valid_o, frame_err_o, busy_o});
    end
    rstn_i = 1'b1;
    idle(4);
    sb.push_back('{8'h3C, 1'b0, 1'b0});
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    idle(4);
    checks++;
    if (sb.size() != 0 || data_o !== 8'h3C) begin
      errors++;
      $display("FAIL midframe_recover: pending=%0d data_o=%h, required 0 and 3c", sb.size(), data_o);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    sb.push_back('{8'h3C, 1'b0, 1'b1});
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    idle(4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL parity_drained: pending=%0d, required 0", sb.size());
    end
  endtask
`endif

  initial begin
    test_reset;
    test_valid_frame;
    test_frame_err;
    test_glitch;
    test_spike;
    test_back_to_back;
    test_reset_midframe;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
